// File: rtl/clk_freq_monitor.sv
// ---------------------------------------------------------------------------
// clk_freq_monitor : checks that mon_in toggles with the expected period in
//                    clk_in cycles, locks after a run of good periods.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clk_freq_monitor #(
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 0,
  parameter int GOOD_COUNT = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       mon_in,
  output logic       locked,
  output logic [7:0] period_last,
  output logic       period_valid,
  output logic       lost,
  output logic [7:0] err_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int          LO_RAW    = EXP_PERIOD - TOL;
  localparam int unsigned WIN_LO    = (LO_RAW < 1) ? 32'd1 : 32'(LO_RAW);
  localparam int unsigned WIN_HI    = 32'(EXP_PERIOD + TOL);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);
  localparam int          GW        = $clog2(GOOD_COUNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_COUNT - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [7:0]    cnt_q, cnt_d;
  logic [GW-1:0] good_q;
  state_t        state_q;
  logic          locked_q, valid_q, lost_q;
  logic [7:0]    period_last_q, err_q, err_d;

  logic          edge_pulse;
  logic [7:0]    meas;
  logic          in_window;
  logic          timeout_hit;

  assign edge_pulse  = sync2_q & ~prev_q;
  assign meas        = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
  assign in_window   = ({24'd0, meas} >= WIN_LO) && ({24'd0, meas} <= WIN_HI);
  assign timeout_hit = (cnt_q == TO_LAST);
  assign cnt_d       = edge_pulse ? 8'd0 : ((cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1);
  assign err_d       = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      cnt_q         <= 8'd0;
      good_q        <= '0;
      state_q       <= SEARCH;
      locked_q      <= 1'b0;
      valid_q       <= 1'b0;
      lost_q        <= 1'b0;
      period_last_q <= 8'd0;
      err_q         <= 8'd0;
    end else begin
      sync1_q <= mon_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (edge_pulse) begin
            state_q <= MEASURE;
            good_q  <= '0;
          end
        end
        MEASURE, LOCKED: begin
          // An edge wins over a simultaneous timeout.
          if (edge_pulse) begin
            period_last_q <= meas;
            valid_q       <= 1'b1;
            if (in_window) begin
              if (state_q == MEASURE) begin
                good_q <= good_q + GW'(1);
                if (good_q == GOOD_LAST) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end else begin
              good_q   <= '0;
              err_q    <= err_d;
              state_q  <= MEASURE;
              locked_q <= 1'b0;
            end
          end else if (timeout_hit) begin
            lost_q   <= 1'b1;
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            err_q    <= err_d;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign locked       = locked_q;
  assign period_last  = period_last_q;
  assign period_valid = valid_q;
  assign lost         = lost_q;
  assign err_count    = err_q;
  assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_freq_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_freq_monitor : scoreboard bench for clk_freq_monitor (default and
//                       TOL=1 instances).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clk_freq_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       mon0 = 1'b0, mon1 = 1'b0;
  logic       lk0, pv0, lost0, lk1, pv1, lost1;
  logic [7:0] pl0, err0, pl1, err1;
  logic [1:0] st0, st1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] p;
    logic       lk;
    logic [7:0] err;
    logic [1:0] st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   prev_len[2];
  int   last_valid_cyc = 0;
  int   lost_cnt = 0;
  int   lost_cyc = 0;

  clk_freq_monitor u_dut (
    .clk_in(clk), .reset_n(reset_n), .mon_in(mon0), .locked(lk0),
    .period_last(pl0), .period_valid(pv0), .lost(lost0),
    .err_count(err0), .state(st0)
  );

  clk_freq_monitor #(.TOL(1)) u_dut_tol (
    .clk_in(clk), .reset_n(reset_n), .mon_in(mon1), .locked(lk1),
    .period_last(pl1), .period_valid(pv1), .lost(lost1),
    .err_count(err1), .state(st1)
  );

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (pv0) begin
        vectors++;
        if (q0.size() == 0) begin
          miscompares++;
          $display("FAIL sb0_unexpected: got p=%0d lk=%0b err=%0d st=%0d, required no period_valid",
                   pl0, lk0, err0, st0);
        end else begin
          e = q0.pop_front();
          if ({pl0, lk0, err0, st0} !== e) begin
            miscompares++;
            $display("FAIL sb0_period: got p=%0d lk=%0b err=%0d st=%0d, required p=%0d lk=%0b err=%0d st=%0d",
                     pl0, lk0, err0, st0, e.p, e.lk, e.err, e.st);
          end
        end
        last_valid_cyc = cyc;
      end
      if (lost0) begin
        lost_cnt++;
        lost_cyc = cyc;
      end
      if (pv1) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL sb1_unexpected: got p=%0d lk=%0b err=%0d st=%0d, required no period_valid",
                   pl1, lk1, err1, st1);
        end else begin
          e = q1.pop_front();
          if ({pl1, lk1, err1, st1} !== e) begin
            miscompares++;
            $display("FAIL sb1_period: got p=%0d lk=%0b err=%0d st=%0d, required p=%0d lk=%0b err=%0d st=%0d",
                     pl1, lk1, err1, st1, e.p, e.lk, e.err, e.st);
          end
        end
      end
    end
  endtask

  // One mon period: rising edge then hi cycles high, lo cycles low. The edge
  // closes the previous period, so its expectation is pushed here.
  task automatic period(input bit sel, input int hi, input int lo, input bit push,
                        input bit lk, input int err, input logic [1:0] st);
    exp_t e;
    if (push) begin
      e.p   = (prev_len[sel] > 255) ? 8'd255 : 8'(prev_len[sel]);
      e.lk  = lk;
      e.err = 8'(err);
      e.st  = st;
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
    end
    prev_len[sel] = hi + lo;
    if (sel) mon1 = 1'b1; else mon0 = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    if (sel) mon1 = 1'b0; else mon0 = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit sel, input string name);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      if ((sel ? q1.size() : q0.size()) == 0) break;
      @(posedge clk);
      #1;
      n++;
    end
    prev_len[sel] += n;
    vectors++;
    if ((sel ? q1.size() : q0.size()) != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d results pending, required 0", name,
               sel ? q1.size() : q0.size());
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mon0 = 1'b0;
    mon1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic lock0();
    period(1'b0, 4, 4, 1'b0, 1'b0, 0, 2'd0);
    for (int k = 2; k <= 17; k++)
      period(1'b0, 4, 4, 1'b1, (k == 17), 0, (k == 17) ? 2'd2 : 2'd1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (lk0 !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b, required 0", lk0); end
    vectors++; if (pl0 !== 8'd0) begin miscompares++; $display("FAIL reset_period_last: got %0d, required 0", pl0); end
    vectors++; if (pv0 !== 1'b0) begin miscompares++; $display("FAIL reset_period_valid: got %b, required 0", pv0); end
    vectors++; if (lost0 !== 1'b0) begin miscompares++; $display("FAIL reset_lost: got %b, required 0", lost0); end
    vectors++; if (err0 !== 8'd0) begin miscompares++; $display("FAIL reset_err: got %0d, required 0", err0); end
    vectors++; if (st0 !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d, required 0", st0); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_lock();
    do_reset();
    lock0();
    drain(1'b0, "lock");
    vectors++; if (st0 !== 2'd2) begin miscompares++; $display("FAIL lock_state: got %0d, required 2", st0); end
    vectors++; if (lk0 !== 1'b1) begin miscompares++; $display("FAIL lock_locked: got %b, required 1", lk0); end
  endtask

  task automatic test_glitch();
    period(1'b0, 5, 5, 1'b1, 1'b1, 0, 2'd2);
    period(1'b0, 4, 4, 1'b1, 1'b0, 1, 2'd1);
    for (int i = 1; i <= 16; i++)
      period(1'b0, 4, 4, 1'b1, (i == 16), 1, (i == 16) ? 2'd2 : 2'd1);
    drain(1'b0, "glitch");
    vectors++; if (err0 !== 8'd1) begin miscompares++; $display("FAIL glitch_err: got %0d, required 1", err0); end
  endtask

  task automatic test_timeout();
    do_reset();
    lock0();
    drain(1'b0, "timeout_lock");
    lost_cnt = 0;
    repeat (600) @(posedge clk);
    #1;
    vectors++; if (lost_cnt != 1) begin miscompares++; $display("FAIL timeout_lost_count: got %0d, required 1", lost_cnt); end
    vectors++; if (lost_cyc - last_valid_cyc != 255) begin miscompares++;
      $display("FAIL timeout_delay: got %0d, required 255", lost_cyc - last_valid_cyc); end
    vectors++; if (st0 !== 2'd0) begin miscompares++; $display("FAIL timeout_state: got %0d, required 0", st0); end
    vectors++; if (lk0 !== 1'b0) begin miscompares++; $display("FAIL timeout_locked: got %b, required 0", lk0); end
    vectors++; if (err0 !== 8'd1) begin miscompares++; $display("FAIL timeout_err: got %0d, required 1", err0); end
  endtask

  task automatic test_reset_midlock();
    do_reset();
    lock0();
    drain(1'b0, "midlock_lock");
    vectors++; if (st0 !== 2'd2) begin miscompares++; $display("FAIL midlock_pre_state: got %0d, required 2", st0); end
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    vectors++; if ({lk0, pl0, pv0, lost0, err0, st0} !== 20'd0) begin miscompares++;
      $display("FAIL midlock_clear: got lk=%b p=%0d pv=%b lost=%b err=%0d st=%0d, required all 0",
               lk0, pl0, pv0, lost0, err0, st0); end
    lock0();
    drain(1'b0, "midlock_relock");
    vectors++; if (lk0 !== 1'b1) begin miscompares++; $display("FAIL midlock_relock: got %b, required 1", lk0); end
  endtask

  task automatic test_saturate();
    do_reset();
    period(1'b0, 2, 3, 1'b0, 1'b0, 0, 2'd0);
    for (int k = 2; k <= 300; k++)
      period(1'b0, 2, 3, 1'b1, 1'b0, (k - 1 > 255) ? 255 : k - 1, 2'd1);
    drain(1'b0, "saturate");
    vectors++; if (err0 !== 8'd255) begin miscompares++; $display("FAIL saturate_err: got %0d, required 255", err0); end
    vectors++; if (lk0 !== 1'b0) begin miscompares++; $display("FAIL saturate_locked: got %b, required 0", lk0); end
  endtask

  task automatic test_tol();
    int len;
    do_reset();
    period(1'b1, 3, 4, 1'b0, 1'b0, 0, 2'd0);
    for (int i = 1; i <= 16; i++) begin
      len = (i == 16) ? 6 : ((i % 2) ? 9 : 7);
      period(1'b1, 3, len - 3, 1'b1, (i == 16), 0, (i == 16) ? 2'd2 : 2'd1);
    end
    period(1'b1, 4, 4, 1'b1, 1'b0, 1, 2'd1);
    drain(1'b1, "tol");
    vectors++; if (lk1 !== 1'b0) begin miscompares++; $display("FAIL tol_locked: got %b, required 0", lk1); end
    vectors++; if (err1 !== 8'd1) begin miscompares++; $display("FAIL tol_err: got %0d, required 1", err1); end
  endtask

  initial begin
    prev_len[0] = 0;
    prev_len[1] = 0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_lock();
    test_glitch();
    test_timeout();
    test_reset_midlock();
    test_saturate();
    test_tol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
